// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state encoding and the legal probe width range.
package sar_search_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TEST = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  function automatic bit width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/sar_bit_slice.sv
// One bit of the search datapath: next acc/mask/probe for a single bit
// position. The mask shifts down by taking the neighbouring upper slice's bit.
module sar_bit_slice #(
  parameter bit IS_MSB = 1'b0
) (
  input  logic load,
  input  logic shift,
  input  logic last,
  input  logic le,
  input  logic acc_q,
  input  logic mask_q,
  input  logic mask_up,
  input  logic probe_q,
  output logic acc_d,
  output logic mask_d,
  output logic probe_d
);

  always_comb begin
    acc_d   = acc_q;
    mask_d  = mask_q;
    probe_d = 1'b0;
    if (load) begin
      acc_d   = 1'b0;
      mask_d  = IS_MSB;
      probe_d = IS_MSB;
    end else if (shift) begin
      if (le) begin
        acc_d = probe_q;
      end
      mask_d = mask_up;
      // After the last trial the probe returns to zero for DONE.
      probe_d = last ? 1'b0 : (acc_d | mask_up);
    end
  end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives PROBE MSB first to an
// external unsigned <= comparator and converges on the largest probe <= target.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             START,
  output logic [WIDTH-1:0] PROBE,
  input  logic             LE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [1:0]       DBG_STATE
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("sar_search: WIDTH out of range");
  end

  // Handshake: START is accepted on an enabled edge in IDLE or DONE only;
  // DONE is a one-enabled-cycle pulse and RESULT holds until the next DONE.

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             load;
  logic             shift;
  logic [WIDTH-1:0] slice_acc;
  logic [WIDTH-1:0] slice_mask;
  logic [WIDTH-1:0] slice_probe;

  always_comb begin
    load  = START && (state_q != ST_TEST);
    shift = (state_q == ST_TEST);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic mask_up;
    if (i == WIDTH - 1) begin : g_top
      assign mask_up = 1'b0;
    end else begin : g_mid
      assign mask_up = mask_q[i+1];
    end

    sar_bit_slice #(
      .IS_MSB (i == WIDTH - 1)
    ) u_slice (
      .load    (load),
      .shift   (shift),
      .last    (mask_q[0]),
      .le      (LE),
      .acc_q   (acc_q[i]),
      .mask_q  (mask_q[i]),
      .mask_up (mask_up),
      .probe_q (probe_q[i]),
      .acc_d   (slice_acc[i]),
      .mask_d  (slice_mask[i]),
      .probe_d (slice_probe[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mask_d   = mask_q;
    probe_d  = probe_q;
    result_d = result_q;
    if (CE) begin
      case (state_q)
        ST_IDLE: begin
          probe_d = '0;
          if (START) begin
            state_d = ST_TEST;
            acc_d   = slice_acc;
            mask_d  = slice_mask;
            probe_d = slice_probe;
          end
        end
        ST_TEST: begin
          acc_d   = slice_acc;
          mask_d  = slice_mask;
          probe_d = slice_probe;
          if (mask_q[0]) begin
            result_d = slice_acc;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: begin
          probe_d = '0;
          if (START) begin
            state_d = ST_TEST;
            acc_d   = slice_acc;
            mask_d  = slice_mask;
            probe_d = slice_probe;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          probe_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mask_q   <= '0;
      probe_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      probe_q  <= probe_d;
      result_q <= result_d;
    end
  end

  assign PROBE     = probe_q;
  assign BUSY      = (state_q == ST_TEST);
  assign DONE      = (state_q == ST_DONE);
  assign RESULT    = result_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: an 8-bit and a 4-bit instance, each with
// a behavioural unsigned <= comparator closing the LE loop.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       start;
  logic [7:0] tgt8;
  logic [3:0] tgt4;

  logic [7:0] probe8, result8;
  logic       busy8, done8, le8;
  logic [1:0] dbg8;
  logic [3:0] probe4, result4;
  logic       busy4, done4, le4;
  logic [1:0] dbg4;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  logic [15:0] res_q[$];

  always #5 clk = ~clk;

  assign le8 = (probe8 <= tgt8);
  assign le4 = (probe4 <= tgt4);

  sar_search #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET(rst), .CE(ce), .START(start), .PROBE(probe8), .LE(le8),
    .BUSY(busy8), .DONE(done8), .RESULT(result8), .DBG_STATE(dbg8)
  );

  sar_search #(.WIDTH(4)) dut4 (
    .CLK(clk), .RESET(rst), .CE(ce), .START(start), .PROBE(probe4), .LE(le4),
    .BUSY(busy4), .DONE(done4), .RESULT(result4), .DBG_STATE(dbg4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_exp(output logic [15:0] v);
    vectors++;
    assert (exp_q.size() > 0) else begin
      miscompares++;
      $error("FAIL scoreboard_probe_empty: observed 0 entries expected >0");
    end
    v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
  endtask

  task automatic pop_res(output logic [15:0] v);
    vectors++;
    assert (res_q.size() > 0) else begin
      miscompares++;
      $error("FAIL scoreboard_result_empty: observed 0 entries expected >0");
    end
    v = (res_q.size() > 0) ? res_q.pop_front() : 16'hxxxx;
  endtask

  function automatic logic [15:0] o_probe(input int w);
    return (w == 8) ? {8'h00, probe8} : {12'h000, probe4};
  endfunction
  function automatic logic [15:0] o_result(input int w);
    return (w == 8) ? {8'h00, result8} : {12'h000, result4};
  endfunction
  function automatic logic o_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction
  function automatic logic o_done(input int w);
    return (w == 8) ? done8 : done4;
  endfunction

  // Reference search: try each bit MSB first, keep it if the trial is <= target.
  task automatic push_model(input int w, input logic [15:0] tgt);
    logic [15:0] acc, p;
    acc = '0;
    for (int i = w - 1; i >= 0; i--) begin
      p = acc | (16'd1 << i);
      exp_q.push_back(p);
      if (p <= tgt) acc = p;
    end
    res_q.push_back(acc);
  endtask

  task automatic search(input int w, input logic [15:0] tgt, input bit use_model);
    logic [15:0] e;
    if (w == 8) tgt8 = tgt[7:0];
    else        tgt4 = tgt[3:0];
    if (use_model) push_model(w, tgt);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= w; c++) begin
      pop_exp(e);
      check("probe", o_probe(w), e);
      check("busy_in_test", {15'b0, o_busy(w)}, 16'd1);
      check("done_in_test", {15'b0, o_done(w)}, 16'd0);
      tick();
    end
    pop_res(e);
    check("done_pulse", {15'b0, o_done(w)}, 16'd1);
    check("busy_at_done", {15'b0, o_busy(w)}, 16'd0);
    check("probe_at_done", o_probe(w), 16'd0);
    check("result", o_result(w), e);
    tick();
    check("done_one_cycle", {15'b0, o_done(w)}, 16'd0);
    check("result_holds", o_result(w), e);
  endtask

  initial begin
    logic [15:0] e, cur, r;
    rst   = 1'b1;
    ce    = 1'b1;
    start = 1'b0;
    tgt8  = 8'h00;
    tgt4  = 4'h0;
    tick();
    start = 1'b1;
    tick();
    check("rst_probe", {8'h00, probe8}, 16'd0);
    check("rst_busy", {15'b0, busy8}, 16'd0);
    check("rst_done", {15'b0, done8}, 16'd0);
    check("rst_result", {8'h00, result8}, 16'd0);
    start = 1'b0;
    rst   = 1'b0;
    tick();

    // Known trial sequence for target 0xA5.
    exp_q.push_back(16'h80); exp_q.push_back(16'hC0);
    exp_q.push_back(16'hA0); exp_q.push_back(16'hB0);
    exp_q.push_back(16'hA8); exp_q.push_back(16'hA4);
    exp_q.push_back(16'hA6); exp_q.push_back(16'hA5);
    res_q.push_back(16'hA5);
    search(8, 16'hA5, 1'b0);

    search(8, 16'h00, 1'b1);
    search(8, 16'hFF, 1'b1);
    search(8, 16'h37, 1'b1);

    // Reset in cycle 4 of a search.
    tgt8 = 8'h3C;
    push_model(8, 16'h3C);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      pop_exp(e);
      check("rst_probe_pre", {8'h00, probe8}, e);
      if (c == 4) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    check("midrst_probe", {8'h00, probe8}, 16'd0);
    check("midrst_busy", {15'b0, busy8}, 16'd0);
    check("midrst_result", {8'h00, result8}, 16'd0);
    check("midrst_done", {15'b0, done8}, 16'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("midrst_no_done", {15'b0, done8}, 16'd0);
    end
    exp_q.delete();
    res_q.delete();
    search(8, 16'h3C, 1'b1);

    // Back-to-back with START held, then toggled during the second search.
    tgt8 = 8'h5A;
    push_model(8, 16'h5A);
    push_model(8, 16'h5A);
    start = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      pop_exp(e);
      check("b2b_probe1", {8'h00, probe8}, e);
      tick();
    end
    pop_res(r);
    check("b2b_done1", {15'b0, done8}, 16'd1);
    check("b2b_result1", {8'h00, result8}, r);
    tick();
    for (int c = 10; c <= 17; c++) begin
      pop_exp(e);
      check("b2b_probe2", {8'h00, probe8}, e);
      check("b2b_busy2", {15'b0, busy8}, 16'd1);
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    pop_res(r);
    check("b2b_done2", {15'b0, done8}, 16'd1);
    check("b2b_result2", {8'h00, result8}, r);
    tick();
    check("b2b_idle_done", {15'b0, done8}, 16'd0);
    check("b2b_idle_busy", {15'b0, busy8}, 16'd0);

    // CE low in cycles 3..5 freezes the trial of cycle 3 for three extra cycles.
    tgt8 = 8'h81;
    push_model(8, 16'h81);
    start = 1'b1;
    tick();
    start = 1'b0;
    cur = '0;
    for (int c = 1; c <= 11; c++) begin
      if (c < 4 || c > 6) pop_exp(cur);
      check("ce_probe", {8'h00, probe8}, cur);
      check("ce_busy", {15'b0, busy8}, 16'd1);
      check("ce_done", {15'b0, done8}, 16'd0);
      ce = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      tick();
    end
    pop_res(r);
    check("ce_done_c12", {15'b0, done8}, 16'd1);
    check("ce_result", {8'h00, result8}, r);
    ce = 1'b0;
    tick();
    check("ce_done_held", {15'b0, done8}, 16'd1);
    ce = 1'b1;
    tick();
    check("ce_done_clear", {15'b0, done8}, 16'd0);

    // Every 4-bit target.
    for (int t = 0; t < 16; t++) begin
      search(4, 16'(t), 1'b1);
      check("sweep_eq_target", {12'h000, result4}, 16'(t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
